// File: rtl/fe_fetch_redirect.sv
// Fetch stage: owns the PC, reads imem combinationally, fills the one-deep FE->DE latch.
// Optional FE_PERF_CNT_EN adds redirect/stall performance counters.
module fe_fetch_redirect #(
  parameter int                   DBITS    = 32,
  parameter int                   INSTBITS = 32,
  parameter logic [DBITS-1:0]     STARTPC  = 'h100,
  parameter int                   IMEM_AW  = 14,
  parameter logic [INSTBITS-1:0]  NOP_INST = 'h13
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DBITS:0]              from_AGEX_to_FE,
  input  logic                        stall_DE,
  output logic [IMEM_AW-1:0]          imem_addr,
  input  logic [INSTBITS-1:0]         imem_rdata,
`ifdef FE_PERF_CNT_EN
  output logic [DBITS-1:0]            perf_redirects,
  output logic [DBITS-1:0]            perf_stalls,
`endif
  output logic [INSTBITS+3*DBITS:0]   FE_latch_out
);

  typedef struct packed {
    logic                 valid;
    logic [INSTBITS-1:0]  inst;
    logic [DBITS-1:0]     pc;
    logic [DBITS-1:0]     pcplus;
    logic [DBITS-1:0]     inst_count;
  } fe_latch_t;

  logic             br_cond;
  logic [DBITS-1:0] br_target;
  logic [DBITS-1:0] pc;
  logic [DBITS-1:0] pc_plus4;
  logic [DBITS-1:0] inst_count;
  fe_latch_t        latch;

  assign br_cond   = from_AGEX_to_FE[DBITS];
  assign br_target = from_AGEX_to_FE[DBITS-1:0];
  assign pc_plus4  = pc + DBITS'(4);
  assign imem_addr = pc[IMEM_AW+1:2];
  assign FE_latch_out = latch;

  // Redirect beats stall: DE squashes its own copy in the same cycle, so the
  // bubble must land even when DE is not accepting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc               <= STARTPC;
      inst_count       <= '0;
      latch.valid      <= 1'b0;
      latch.inst       <= NOP_INST;
      latch.pc         <= '0;
      latch.pcplus     <= '0;
      latch.inst_count <= '0;
    end else if (br_cond) begin
      pc               <= br_target;
      latch.valid      <= 1'b0;
      latch.inst       <= NOP_INST;
      latch.pc         <= '0;
      latch.pcplus     <= '0;
      latch.inst_count <= inst_count;
    end else if (!stall_DE) begin
      pc               <= pc_plus4;
      inst_count       <= inst_count + DBITS'(1);
      latch.valid      <= 1'b1;
      latch.inst       <= imem_rdata;
      latch.pc         <= pc;
      latch.pcplus     <= pc_plus4;
      latch.inst_count <= inst_count + DBITS'(1);
    end
  end

`ifdef FE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_redirects <= '0;
      perf_stalls    <= '0;
    end else if (br_cond) begin
      perf_redirects <= perf_redirects + DBITS'(1);
    end else if (stall_DE) begin
      perf_stalls    <= perf_stalls + DBITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fe_fetch_redirect.sv
// Directed bench for fe_fetch_redirect: imem word w holds value w.
module tb_fe_fetch_redirect;
  logic         clk = 1'b0;
  logic         reset;
  logic [32:0]  from_AGEX_to_FE;
  logic         stall_DE;
  logic [13:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic [128:0] FE_latch_out;
`ifdef FE_PERF_CNT_EN
  logic [31:0]  perf_redirects;
  logic [31:0]  perf_stalls;
`endif
  int tests = 0;
  int fails = 0;

  fe_fetch_redirect dut (
    .clk(clk), .reset(reset), .from_AGEX_to_FE(from_AGEX_to_FE), .stall_DE(stall_DE),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
`ifdef FE_PERF_CNT_EN
    .perf_redirects(perf_redirects), .perf_stalls(perf_stalls),
`endif
    .FE_latch_out(FE_latch_out)
  );

  always #5 clk = ~clk;
  assign imem_rdata = {18'b0, imem_addr};

  wire        l_valid = FE_latch_out[128];
  wire [31:0] l_inst  = FE_latch_out[127:96];
  wire [31:0] l_pc    = FE_latch_out[95:64];
  wire [31:0] l_pcp   = FE_latch_out[63:32];
  wire [31:0] l_cnt   = FE_latch_out[31:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_valid(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, ".valid"}, {31'b0, l_valid}, 32'd1);
    chk({tag, ".inst"},  l_inst, {18'b0, pc[15:2]});
    chk({tag, ".pc"},    l_pc, pc);
    chk({tag, ".pcplus"}, l_pcp, pc + 32'd4);
    chk({tag, ".cnt"},   l_cnt, cnt);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, {31'b0, l_valid}, 32'd0);
    chk({tag, ".inst"},  l_inst, 32'h13);
  endtask

  initial begin
    reset = 1'b0; stall_DE = 1'b0; from_AGEX_to_FE = '0;
    // T1: reset held, then straight-line fetch
    repeat (3) step();
    chk("rst.valid", {31'b0, l_valid}, 32'd0);
    chk("rst.inst", l_inst, 32'h13);
    chk("rst.pc", l_pc, 32'd0);
    chk("rst.pcplus", l_pcp, 32'd0);
    chk("rst.cnt", l_cnt, 32'd0);
    chk("rst.imem_addr", {18'b0, imem_addr}, 32'h40);
    reset = 1'b1;
    step(); chk_valid("t1a", 32'h100, 32'd1);
    step(); chk_valid("t1b", 32'h104, 32'd2);
    step(); chk_valid("t1c", 32'h108, 32'd3);

    // T2: redirect from 0x10C to 0x200
    from_AGEX_to_FE = {1'b1, 32'h200};
    step(); chk_bubble("t2.bub");
    from_AGEX_to_FE = '0;
    step(); chk_valid("t2.tgt", 32'h200, 32'd4);

    // T3: three stall cycles freeze latch and PC
    stall_DE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3.hold.pc", l_pc, 32'h200);
      chk("t3.hold.cnt", l_cnt, 32'd4);
      chk("t3.hold.addr", {18'b0, imem_addr}, 32'h81);
    end
    stall_DE = 1'b0;
    step(); chk_valid("t3.rel", 32'h204, 32'd5);
    step(); chk_valid("t3.next", 32'h208, 32'd6);

    // T4: stall and redirect together, redirect wins
    stall_DE = 1'b1; from_AGEX_to_FE = {1'b1, 32'h300};
    step(); chk_bubble("t4.bub");
    stall_DE = 1'b0; from_AGEX_to_FE = '0;
    step(); chk_valid("t4.tgt", 32'h300, 32'd7);

    // T5: back-to-back redirects, 0x400 never delivered
    from_AGEX_to_FE = {1'b1, 32'h400};
    step(); chk_bubble("t5.bub1");
    from_AGEX_to_FE = {1'b1, 32'h500};
    step(); chk_bubble("t5.bub2");
    chk("t5.addr", {18'b0, imem_addr}, 32'h140);
    from_AGEX_to_FE = '0;
    step(); chk_valid("t5.tgt", 32'h500, 32'd8);

    // PC wrap at the top of the address space
    from_AGEX_to_FE = {1'b1, 32'hFFFF_FFFC};
    step(); chk_bubble("wrap.bub");
    from_AGEX_to_FE = '0;
    step();
    chk("wrap.pc", l_pc, 32'hFFFF_FFFC);
    chk("wrap.pcplus", l_pcp, 32'h0);
    chk("wrap.inst", l_inst, 32'h3FFF);
    chk("wrap.cnt", l_cnt, 32'd9);
    step(); chk_valid("wrap.zero", 32'h0, 32'd10);

`ifdef FE_PERF_CNT_EN
    chk("perf.redirects", perf_redirects, 32'd5);
    chk("perf.stalls", perf_stalls, 32'd3);
`endif

    // T6: async reset mid-cycle with a redirect pending
    from_AGEX_to_FE = {1'b1, 32'h600};
    #2 reset = 1'b0;
    #1;
    chk("t6.valid", {31'b0, l_valid}, 32'd0);
    chk("t6.cnt", l_cnt, 32'd0);
    chk("t6.addr", {18'b0, imem_addr}, 32'h40);
`ifdef FE_PERF_CNT_EN
    chk("t6.perf_redirects", perf_redirects, 32'd0);
    chk("t6.perf_stalls", perf_stalls, 32'd0);
`endif
    step();
    from_AGEX_to_FE = '0;
    reset = 1'b1;
    step(); chk_valid("t6.restart", 32'h100, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
